adder_rr_arbiter: RTL

//  Shares one 4-bit ripple adder (5-bit sum, carry-in tied 0) between NUM_REQ requesters.

---
 rtl/adder_rr_arbiter_if.sv | 27 ++
 rtl/adder_rr_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter_if.sv
// Requester/consumer bundle for the shared-adder round-robin arbiter.
// The master side belongs to the requester front-ends and the result consumer.
// The slave side belongs to the arbiter.
interface adder_rr_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [4*NUM_REQ-1:0] req_a;
   logic [4*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 rsp_valid;
   logic [4:0]           rsp_sum;
   logic [ID_W-1:0]      rsp_id;
   logic                 rsp_ready;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_id
   );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that shares one 4-bit ripple adder between NUM_REQ
// requesters. Each result sits in a single output register, tagged with the
// requester index. A drain and a refill can happen in the same cycle, which
// gives one result per cycle.

// 4-bit ripple-carry adder with carry-in tied low; bit 4 of the sum is the carry out.
module adder_rr_ripple4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [4:0] o_sum
);
   logic [4:0] w_carry;

   assign w_carry[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_fa
         assign o_sum[gi]     = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
         assign w_carry[gi+1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
      end
   endgenerate

   assign o_sum[4] = w_carry[4];
endmodule

module adder_rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input logic                 clk,
   input logic                 rst_n,
   adder_rr_arbiter_if.slave   bus
);
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]            r_state;
   logic [ID_W-1:0]       r_rr_ptr;
   logic [4:0]            r_sum;
   logic [ID_W-1:0]       r_id;
   logic                  r_init_done;

   logic                  w_can_issue;
   logic [2*NUM_REQ-1:0]  w_valid_dbl;
   logic [2*NUM_REQ-1:0]  w_valid_shift;
   logic [NUM_REQ-1:0]    w_valid_rot;
   logic                  w_found;
   logic [ID_W-1:0]       w_off;
   logic [ID_W:0]         w_idx_sum;
   logic [ID_W-1:0]       w_gnt_idx;
   logic                  w_grant;
   logic [ID_W-1:0]       w_ptr_next;
   logic [3:0]            w_op_a_arr [NUM_REQ];
   logic [3:0]            w_op_b_arr [NUM_REQ];
   logic [3:0]            w_op_a;
   logic [3:0]            w_op_b;
   logic [4:0]            w_adder_sum;

   // A new pair may be taken when the output register is free or is being drained.
   // The first cycle after reset release never issues.
   assign w_can_issue = r_init_done & ((r_state == ST_EMPTY) | bus.rsp_ready);

   // Rotate the request vector so that bit 0 is the requester at rr_ptr.
   assign w_valid_dbl   = {bus.req_valid, bus.req_valid};
   assign w_valid_shift = w_valid_dbl >> r_rr_ptr;
   assign w_valid_rot   = w_valid_shift[NUM_REQ-1:0];

   // Pick the lowest rotated offset with a pending request.
   always_comb begin
      w_found = 1'b0;
      w_off   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_valid_rot[k]) begin
            w_found = 1'b1;
            w_off   = ID_W'(k);
         end
      end
   end

   // Map the rotated offset back to an absolute requester index (mod NUM_REQ).
   assign w_idx_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
   assign w_gnt_idx = (w_idx_sum >= (ID_W+1)'(NUM_REQ))
                    ? ID_W'(w_idx_sum - (ID_W+1)'(NUM_REQ))
                    : w_idx_sum[ID_W-1:0];
   assign w_grant   = w_found & w_can_issue;

   assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

   // Split the operand buses per requester and drive the one-hot ready vector.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign w_op_a_arr[gi]   = bus.req_a[4*gi +: 4];
         assign w_op_b_arr[gi]   = bus.req_b[4*gi +: 4];
         assign bus.req_ready[gi] = w_grant & (w_gnt_idx == ID_W'(gi));
      end
   endgenerate

   assign w_op_a = w_op_a_arr[w_gnt_idx];
   assign w_op_b = w_op_b_arr[w_gnt_idx];

   adder_rr_ripple4 u_adder (
      .i_a   (w_op_a),
      .i_b   (w_op_b),
      .o_sum (w_adder_sum)
   );

   // Output register, occupancy state and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_EMPTY;
         r_rr_ptr    <= '0;
         r_sum       <= '0;
         r_id        <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_init_done <= 1'b1;
         if (w_grant) begin
            r_state  <= ST_FULL;
            r_sum    <= w_adder_sum;
            r_id     <= w_gnt_idx;
            r_rr_ptr <= w_ptr_next;
         end else if ((r_state == ST_FULL) && bus.rsp_ready) begin
            r_state <= ST_EMPTY;
         end
      end
   end

   assign bus.rsp_valid = (r_state == ST_FULL);
   assign bus.rsp_sum   = r_sum;
   assign bus.rsp_id    = r_id;
endmodule
